im_program_loader: RTL and testbench
====================================

Name: im_program_loader

Overview:
Writer-side counterpart to the core's instruction memory read path. It accepts a framed byte stream (length, instruction bytes, checksum) over a valid/ready interface and writes each instruction byte into instruction memory at consecutive addresses from 0. It holds the 4-stage core in reset (active-low core reset) until a load completes with a good checksum, then releases it. It sits between the host/debug byte link and the IM write port, in front of the processor top level.

Parameters:
ADDR_W, 8, IM address width; matches the 8-bit PC.
DATA_W, 8, instruction width; the frame's length and checksum fields are also DATA_W wide.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  source has a byte on in_data
in_data  input  DATA_W  frame byte
in_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle request to abort or restart and accept a new frame
im_we  output  1  IM write strobe
im_waddr  output  ADDR_W  IM write address
im_wdata  output  DATA_W  IM write data
core_rst_n  output  1  active-low reset to the processor core; 1 = run
load_done  output  1  frame loaded with good checksum
load_err  output  1  frame rejected
words_loaded  output  ADDR_W  count of instruction bytes written in the current frame

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: in_ready=0, im_we=0, im_waddr=0, im_wdata=0, core_rst_n=0, load_done=0, load_err=0, words_loaded=0. State goes to LEN. in_ready rises the cycle after reset deasserts.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is 1 exactly in states LEN, DATA and CHK. Gaps in in_valid are legal and have no effect.
- States: LEN -> DATA -> CHK -> DONE or ERR.
- LEN:
  - On an accepted byte L: if L==0, go to ERR.
  - Otherwise latch remaining=L, clear addr=0, sum=0, words_loaded=0, and go to DATA.
- DATA, per accepted byte b:
  - Next cycle: im_we=1 for exactly one cycle, with im_waddr=addr and im_wdata=b. Write latency is 1 cycle after acceptance.
  - Update addr+=1, sum=(sum+b) mod 2^DATA_W, words_loaded+=1, remaining-=1.
  - When the accepted byte makes remaining 0, go to CHK.
  - Back-to-back accepts produce back-to-back writes.
  - Maximum L=255 writes addresses 0..254; addr never wraps within a frame.
- CHK, on an accepted byte c:
  - If (sum+c) mod 2^DATA_W == 0 (two's-complement checksum), go to DONE; otherwise go to ERR.
  - im_we=0 in CHK.
- DONE: load_done=1, core_rst_n=1, in_ready=0. The state holds until reload or reset.
- ERR: load_err=1, core_rst_n=0, in_ready=0. The state holds until reload or reset.
- core_rst_n is registered and rises on the same edge load_done rises.
- reload, accepted in any state:
  - Next state is LEN; load_done=0, load_err=0, core_rst_n=0, words_loaded=0 on the following edge.
  - Any pending im_we from the previous cycle's accept still completes.
  - Bytes already written to IM are not cleared.
- reload has priority over a byte handshaken in the same cycle. That byte is consumed and discarded: no write, and no change to the checksum or count.
- reset has priority over reload and over every other event.
- reset mid-frame returns all outputs to their reset values on the next edge, including im_we=0, so a pending write is dropped.
- The checksum byte is never written to IM.
- The length byte is never written to IM.

Test Plan:
- Good frame: send 0x03, 0x41, 0x82, 0xC3, 0x7A with in_valid held high. Expect im_we pulses at addresses 0, 1, 2 with data 0x41, 0x82, 0xC3, each one cycle after its accept. Then load_done=1, core_rst_n=1, words_loaded=3, in_ready=0.
- Bad checksum: send 0x02, 0x10, 0x20, then checksum 0x00 (0xD0 required). Expect load_err=1, core_rst_n=0, load_done=0, in_ready=0, and exactly 2 writes.
- Zero length: send 0x00. Expect ERR on the next edge with no im_we. Then pulse reload and expect in_ready=1 and load_err=0.
- Throttled source: send the good frame from the first scenario with in_valid toggled 1-0-0-1 per byte. Expect identical write address/data sequence, no duplicate writes, and DONE.
- Reload mid-DATA and simultaneous accept: after 0x04, 0xAA, assert reload in the same cycle as the 0xBB handshake. Expect 0xBB is not written, state returns to LEN, and a following frame 0x01, 0x55, 0xAB writes 0x55 at address 0 and reaches DONE.
- Reset mid-frame: assert reset in the same cycle as the second data byte's accept. Expect no write for that byte, all outputs at reset values, then in_ready=1 in LEN after reset releases.

Source files
------------

// File: rtl/im_program_loader_if.sv
// Byte-stream input and IM write port between the host link and the program loader.
interface im_program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;

  // master: host/link side that supplies bytes and observes the IM writes
  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_waddr, im_wdata
  );

  // slave: the loader itself
  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/im_program_loader.sv
// Loads a {len, bytes, checksum} frame into IM from address 0; each write lands 1 cycle after accept.
// in_ready is high only while a frame is being received; core stays in reset until a good checksum.
module im_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  im_program_loader_if.slave bus,
  input  logic              reload,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t            state, state_n;
  logic              accept;
  logic              data_wr;
  logic              len_load;
  logic [DATA_W-1:0] chk_sum;
  logic [DATA_W-1:0] remaining;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN;
    else       state <= state_n;
  end

  // reload wins over a byte handshaken in the same cycle; that byte is dropped
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    state_n  = state;
    data_wr  = 1'b0;
    len_load = 1'b0;
    chk_sum  = sum + bus.in_data;
    if (reload) begin
      state_n = S_LEN;
    end else if (accept) begin
      case (state)
        S_LEN: begin
          if (bus.in_data == '0) begin
            state_n = S_ERR;
          end else begin
            state_n  = S_DATA;
            len_load = 1'b1;
          end
        end
        S_DATA: begin
          data_wr = 1'b1;
          if (remaining == DATA_W'(1)) state_n = S_CHK;
        end
        S_CHK:   state_n = (chk_sum == '0) ? S_DONE : S_ERR;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready  <= 1'b0;
      bus.im_we     <= 1'b0;
      bus.im_waddr  <= '0;
      bus.im_wdata  <= '0;
      core_rst_n    <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      words_loaded  <= '0;
      remaining     <= '0;
      sum           <= '0;
      addr          <= '0;
    end else begin
      bus.in_ready <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_CHK);
      bus.im_we    <= data_wr;
      load_done    <= (state_n == S_DONE);
      load_err     <= (state_n == S_ERR);
      core_rst_n   <= (state_n == S_DONE);
      if (data_wr) begin
        bus.im_waddr <= addr;
        bus.im_wdata <= bus.in_data;
        addr         <= addr + 1'b1;
        sum          <= chk_sum;
        words_loaded <= words_loaded + 1'b1;
        remaining    <= remaining - 1'b1;
      end
      if (len_load) begin
        remaining    <= bus.in_data;
        addr         <= '0;
        sum          <= '0;
        words_loaded <= '0;
      end
      if (reload) words_loaded <= '0;
    end
  end

endmodule

// File: tb/tb_im_program_loader.sv
// Bench for im_program_loader: frame vectors from a table plus hand-written reload/reset sequences.
module tb_im_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       reload;
  logic       core_rst_n, load_done, load_err;
  logic [7:0] words_loaded;

  im_program_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  im_program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .reload       (reload),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         due;
  } wr_t;

  wr_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every observed write must match the oldest expected one, at the expected cycle.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", {24'h0, bus.im_waddr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr",  {24'h0, bus.im_waddr}, {24'h0, e.addr});
        chk("wr_data",  {24'h0, bus.im_wdata}, {24'h0, e.data});
        chk("wr_cycle", cyc, e.due);
      end
    end
  end

  // Called on a negedge; the byte is accepted on the following posedge.
  task automatic send_byte(input logic [7:0] b, input bit push, input logic [7:0] a, input int gap);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", {31'h0, bus.in_ready}, 32'h1);
    if (push) sb.push_back('{addr: a, data: b, due: cyc + 1});
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_in_ready",  {31'h0, bus.in_ready}, 32'h1);
    chk("reload_load_err",  {31'h0, load_err},     32'h0);
    chk("reload_load_done", {31'h0, load_done},    32'h0);
    chk("reload_core_rst",  {31'h0, core_rst_n},   32'h0);
    chk("reload_words",     {24'h0, words_loaded}, 32'h0);
  endtask

  task automatic check_end(input string tag, input bit done, input bit err, input logic [7:0] words);
    chk({tag, "_load_done"}, {31'h0, load_done},    {31'h0, done});
    chk({tag, "_load_err"},  {31'h0, load_err},     {31'h0, err});
    chk({tag, "_core_rst"},  {31'h0, core_rst_n},   {31'h0, done});
    chk({tag, "_in_ready"},  {31'h0, bus.in_ready}, 32'h0);
    chk({tag, "_words"},     {24'h0, words_loaded}, {24'h0, words});
    chk({tag, "_sb_empty"},  sb.size(),             32'h0);
  endtask

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b[6];
    int         gap;
    bit         exp_done;
    bit         exp_err;
    logic [7:0] exp_words;
  } vec_t;

  vec_t vec[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{name: "good",     n: 5, b: '{8'h03, 8'h41, 8'h82, 8'hC3, 8'h7A, 8'h00}, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 8'd3};
    vec[1] = '{name: "badsum",   n: 4, b: '{8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00}, gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 8'd2};
    vec[2] = '{name: "zerolen",  n: 1, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 8'd0};
    vec[3] = '{name: "throttle", n: 5, b: '{8'h03, 8'h41, 8'h82, 8'hC3, 8'h7A, 8'h00}, gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_words: 8'd3};
    vec[4] = '{name: "len1",     n: 3, b: '{8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00}, gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_words: 8'd1};

    reset        = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("rst_im_we",    {31'h0, bus.im_we},    32'h0);
    chk("rst_waddr",    {24'h0, bus.im_waddr}, 32'h0);
    chk("rst_wdata",    {24'h0, bus.im_wdata}, 32'h0);
    chk("rst_core_rst", {31'h0, core_rst_n},   32'h0);
    chk("rst_done",     {31'h0, load_done},    32'h0);
    chk("rst_err",      {31'h0, load_err},     32'h0);
    chk("rst_words",    {24'h0, words_loaded}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    for (int v = 0; v < 5; v++) begin
      do_reload();
      for (int i = 0; i < vec[v].n; i++) begin
        bit p;
        p = (i >= 1) && (i <= int'(vec[v].b[0]));
        send_byte(vec[v].b[i], p, 8'(i - 1), vec[v].gap);
      end
      repeat (2) @(negedge clk);
      check_end(vec[v].name, vec[v].exp_done, vec[v].exp_err, vec[v].exp_words);
    end

    // reload in the same cycle as a data handshake: that byte is dropped
    do_reload();
    send_byte(8'h04, 1'b0, 8'h00, 0);
    send_byte(8'hAA, 1'b1, 8'h00, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hBB;
    reload       = 1'b1;
    chk("reload_hs_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    chk("reload_hs_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("reload_hs_words",    {24'h0, words_loaded}, 32'h0);
    send_byte(8'h01, 1'b0, 8'h00, 0);
    send_byte(8'h55, 1'b1, 8'h00, 0);
    send_byte(8'hAB, 1'b0, 8'h00, 0);
    @(negedge clk);
    check_end("reload_hs", 1'b1, 1'b0, 8'd1);

    // reset in the same cycle as the second data byte's accept
    do_reload();
    send_byte(8'h03, 1'b0, 8'h00, 0);
    send_byte(8'h11, 1'b1, 8'h00, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    reset        = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midrst_im_we",    {31'h0, bus.im_we},    32'h0);
    chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("midrst_words",    {24'h0, words_loaded}, 32'h0);
    chk("midrst_waddr",    {24'h0, bus.im_waddr}, 32'h0);
    chk("midrst_wdata",    {24'h0, bus.im_wdata}, 32'h0);
    chk("midrst_core_rst", {31'h0, core_rst_n},   32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rel_ready", {31'h0, bus.in_ready}, 32'h1);
    send_byte(8'h01, 1'b0, 8'h00, 0);
    send_byte(8'h55, 1'b1, 8'h00, 0);
    send_byte(8'hAB, 1'b0, 8'h00, 0);
    @(negedge clk);
    check_end("midrst_after", 1'b1, 1'b0, 8'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
